// File: rtl/var_fifo_pkg.sv
// Shared types and helpers for the variable-size-read byte FIFO.
//   rd_size_e    : encoded read size (1/2/4/8 bytes)
//   size_bytes() : decoded byte count for a read size
//   byte_mask()  : 64-bit mask keeping only the bytes a read returns
package var_fifo_pkg;

  localparam int WORD_BYTES   = 4;
  localparam int MAX_RD_BYTES = 8;

  typedef enum logic [1:0] {
    SZ_1B = 2'b00,
    SZ_2B = 2'b01,
    SZ_4B = 2'b10,
    SZ_8B = 2'b11
  } rd_size_e;

  function automatic logic [3:0] size_bytes(input rd_size_e sz);
    logic [3:0] n;
    case (sz)
      SZ_1B:   n = 4'd1;
      SZ_2B:   n = 4'd2;
      SZ_4B:   n = 4'd4;
      default: n = 4'd8;
    endcase
    return n;
  endfunction

  function automatic logic [63:0] byte_mask(input rd_size_e sz);
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < MAX_RD_BYTES; i++) begin
      if (i < int'(size_bytes(sz))) m[8*i +: 8] = 8'hFF;
    end
    return m;
  endfunction

endpackage

// File: rtl/vrf_byte_mem.sv
// Byte-addressed storage for var_read_fifo.
//   clock   : write clock, rising edge
//   w_en    : store w_data at w_addr..w_addr+3 (wrapping)
//   w_addr  : byte address of the word's byte0
//   w_data  : 32-bit little-endian word
//   r_addr  : byte address of the first read byte
//   r_data  : 8 bytes from r_addr..r_addr+7 (wrapping), combinational
module vrf_byte_mem
  import var_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clock,
  input  logic                  w_en,
  input  logic [ADDR_WIDTH-1:0] w_addr,
  input  logic [31:0]           w_data,
  input  logic [ADDR_WIDTH-1:0] r_addr,
  output logic [63:0]           r_data
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [7:0] mem [DEPTH];

  // NOTE: the storage array has no reset; its contents are only ever read
  // behind the pointers, so clearing it would buy nothing.
  always_ff @(posedge clock) begin
    if (w_en) begin
      for (int i = 0; i < WORD_BYTES; i++) begin
        // Address arithmetic is ADDR_WIDTH bits wide, so it wraps mid-word.
        mem[w_addr + ADDR_WIDTH'(i)] <= w_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    r_data = '0;
    for (int i = 0; i < MAX_RD_BYTES; i++) begin
      r_data[8*i +: 8] = mem[r_addr + ADDR_WIDTH'(i)];
    end
  end

endmodule

// File: rtl/var_read_fifo.sv
// Byte FIFO with fixed 32-bit writes and 1/2/4/8-byte reads.
//   clock, reset_n : rising-edge clock, asynchronous active-low reset
//   w_en, data_in  : push a 32-bit little-endian word when not full
//   r_en, size     : pop 1<<size bytes when at least that many are stored
//   data_out       : read data one cycle after acceptance, upper bytes zero,
//                    holds its value otherwise
//   valid_out      : one-cycle pulse per accepted read
//   empty, full    : count == 0 / count > DEPTH-4, from registered pointers
//   overflow       : pulse, previous cycle's write dropped while full
//   underflow      : pulse, previous cycle's read rejected
//   level          : byte count, only when VRF_LEVEL_EN is defined
module var_read_fifo
  import var_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                w_en,
  input  logic [31:0]         data_in,
  input  logic                r_en,
  input  logic [1:0]          size,
  output logic [63:0]         data_out,
  output logic                valid_out,
  output logic                empty,
  output logic                full,
  output logic                overflow,
  output logic                underflow
`ifdef VRF_LEVEL_EN
  ,
  output logic [ADDR_WIDTH:0] level
`endif
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int PTR_W = ADDR_WIDTH + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [63:0]      data_out_q, data_out_d;
  logic             valid_out_q, valid_out_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic [PTR_W-1:0] count;
  logic [PTR_W-1:0] rd_nbytes;
  logic [63:0]      rd_bytes;
  rd_size_e         rd_size;
  logic             wr_accept;
  logic             rd_accept;

  vrf_byte_mem #(.ADDR_WIDTH(ADDR_WIDTH)) u_mem (
    .clock  (clock),
    .w_en   (wr_accept),
    .w_addr (wr_ptr_q[ADDR_WIDTH-1:0]),
    .w_data (data_in),
    .r_addr (rd_ptr_q[ADDR_WIDTH-1:0]),
    .r_data (rd_bytes)
  );

  // The extra pointer bit lets count distinguish completely full from empty.
  always_comb begin
    count     = wr_ptr_q - rd_ptr_q;
    empty     = (count == '0);
    full      = (count > PTR_W'(DEPTH - WORD_BYTES));
    rd_size   = rd_size_e'(size);
    rd_nbytes = PTR_W'(size_bytes(rd_size));
    // Both sides judge against the start-of-cycle count: a same-cycle read
    // does not make room for the write, nor does the write feed the read.
    wr_accept = w_en & ~full;
    rd_accept = r_en & (count >= rd_nbytes);
  end

  // NOTE: every signal gets a default at the top of the block so no path
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    data_out_d  = data_out_q;
    valid_out_d = rd_accept;
    overflow_d  = w_en & full;
    underflow_d = r_en & ~rd_accept;
    if (wr_accept) wr_ptr_d = wr_ptr_q + PTR_W'(WORD_BYTES);
    if (rd_accept) begin
      rd_ptr_d   = rd_ptr_q + rd_nbytes;
      data_out_d = rd_bytes & byte_mask(rd_size);
    end
  end

  // NOTE: state updates use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign data_out  = data_out_q;
  assign valid_out = valid_out_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

`ifdef VRF_LEVEL_EN
  assign level = count;
`endif

endmodule

// File: tb/tb_var_read_fifo.sv
module tb_var_read_fifo;
  import var_fifo_pkg::*;

  localparam int AW = 4;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        w_en;
  logic [31:0] data_in;
  logic        r_en;
  logic [1:0]  size;
  logic [63:0] data_out;
  logic        valid_out;
  logic        empty;
  logic        full;
  logic        overflow;
  logic        underflow;
`ifdef VRF_LEVEL_EN
  logic [AW:0] level;
`endif

  var_read_fifo #(.ADDR_WIDTH(AW)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .w_en      (w_en),
    .data_in   (data_in),
    .r_en      (r_en),
    .size      (size),
    .data_out  (data_out),
    .valid_out (valid_out),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow)
`ifdef VRF_LEVEL_EN
    ,
    .level     (level)
`endif
  );

  always #5 clock = ~clock;

  logic [63:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every valid_out pulse must match the oldest outstanding read.
  always @(negedge clock) begin
    if (reset_n && valid_out) begin
      if (exp_q.size() == 0) check("valid_without_read", 64'(valid_out), 64'd0);
      else check("data_out", data_out, exp_q.pop_front());
    end
  end

  task automatic step(input logic w, input logic [31:0] d, input logic r, input logic [1:0] sz);
    w_en = w; data_in = d; r_en = r; size = sz;
    @(posedge clock); #1;
    w_en = 1'b0; r_en = 1'b0;
  endtask

  task automatic wr(input logic [31:0] d);
    step(1'b1, d, 1'b0, 2'b00);
  endtask

  task automatic rd(input logic [1:0] sz, input logic [63:0] exp);
    exp_q.push_back(exp);
    step(1'b0, 32'h0, 1'b1, sz);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; w_en = 1'b0; data_in = '0; r_en = 1'b0; size = 2'b00;
    repeat (2) @(posedge clock);
    #1;
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_full", 64'(full), 64'd0);
    check("rst_valid", 64'(valid_out), 64'd0);
    check("rst_data", data_out, 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    check("rst_unf", 64'(underflow), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;

    // 1: two words, one 8-byte read
    wr(32'h44332211);
    wr(32'h88776655);
    rd(2'b11, 64'h8877665544332211);
    check("t1_empty", 64'(empty), 64'd1);

    // 2: mixed small reads from one word, then data_out holds
    wr(32'hDDCCBBAA);
    rd(2'b00, 64'hAA);
    rd(2'b01, 64'hCCBB);
    rd(2'b00, 64'hDD);
    check("t2_empty", 64'(empty), 64'd1);
    step(1'b0, 32'h0, 1'b0, 2'b00);
    check("t2_hold", data_out, 64'hDD);

    // 3: read on empty is rejected
    step(1'b0, 32'h0, 1'b1, 2'b10);
    check("t3_unf", 64'(underflow), 64'd1);
    check("t3_valid", 64'(valid_out), 64'd0);
    check("t3_empty", 64'(empty), 64'd1);
    step(1'b0, 32'h0, 1'b0, 2'b00);
    check("t3_unf_pulse", 64'(underflow), 64'd0);

    // 4: fill, overflow, drain byte by byte across the wrap
    wr(32'h03020100);
    wr(32'h07060504);
    wr(32'h0B0A0908);
    check("t4_not_full_12", 64'(full), 64'd0);
    wr(32'h0F0E0D0C);
    check("t4_full", 64'(full), 64'd1);
    wr(32'hDEADBEEF);
    check("t4_ovf", 64'(overflow), 64'd1);
    step(1'b0, 32'h0, 1'b0, 2'b00);
    check("t4_ovf_pulse", 64'(overflow), 64'd0);
    for (int i = 0; i < 16; i++) rd(2'b00, 64'(i));
    check("t4_empty", 64'(empty), 64'd1);

    // 5: 10 words interleaved with 20 half-word reads
    for (int k = 0; k < 10; k++) begin
      logic [7:0] b;
      b = 8'(8'h40 + 4*k);
      wr({b + 8'd3, b + 8'd2, b + 8'd1, b});
      rd(2'b01, {48'h0, b + 8'd1, b});
      rd(2'b01, {48'h0, b + 8'd3, b + 8'd2});
    end
    check("t5_empty", 64'(empty), 64'd1);

    // 6: same-cycle write and read on empty, then partial-read rejection
    step(1'b1, 32'h12345678, 1'b1, 2'b00);
    check("t6_unf", 64'(underflow), 64'd1);
    check("t6_valid", 64'(valid_out), 64'd0);
    check("t6_not_empty", 64'(empty), 64'd0);
    step(1'b0, 32'h0, 1'b1, 2'b11);
    check("t6_unf_8b", 64'(underflow), 64'd1);
    rd(2'b00, 64'h78);
    rd(2'b01, 64'h3456);
    rd(2'b00, 64'h12);
    check("t6_empty", 64'(empty), 64'd1);

    // 7: asynchronous reset with a read in flight
    wr(32'h11111111);
    wr(32'h22222222);
    rd(2'b00, 64'h11);
    r_en = 1'b1; size = 2'b10;
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("t7_data", data_out, 64'd0);
    check("t7_valid", 64'(valid_out), 64'd0);
    check("t7_empty", 64'(empty), 64'd1);
    check("t7_full", 64'(full), 64'd0);
    r_en = 1'b0;
    @(posedge clock); #1;
    check("t7_no_inflight_valid", 64'(valid_out), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
    wr(32'hCAFEF00D);
    rd(2'b10, 64'hCAFEF00D);

    repeat (3) @(posedge clock);
    #1;
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
